// File: rtl/bm_uniform_former.sv
// bm_uniform_former
// Packs pairs of 32-bit uniform words from the Tausworthe URNG into one
// Box-Muller operand set: a wide, never-zero u0 for the -ln path and a narrow
// u1 for the cos/sin path. A 2-entry first-word-fall-through buffer
// decouples the free-running URNG from the stalling downstream pipeline.
module bm_uniform_former #(
    parameter int pU0_W  = 48,
    parameter int pU1_W  = 64 - pU0_W,
    parameter int pCNT_W = 8
) (
    input  logic              iclk,
    input  logic              ireset_n,
    input  logic              iclkena,
    input  logic              iclear,
    input  logic              ival,
    input  logic [31:0]       idat,
    output logic              ordy,
    output logic              oval,
    output logic [pU0_W-1:0]  ou0,
    output logic [pU1_W-1:0]  ou1,
    input  logic              irdy,
    output logic [pCNT_W-1:0] ozero_cnt
);

    localparam int cPAIR_W = pU0_W + pU1_W;
    localparam int cLOW_W  = pU0_W - 32;

    localparam logic [0:0] S_A = 1'b0;
    localparam logic [0:0] S_B = 1'b1;

    logic [0:0]         r_state;
    logic [31:0]        r_hold;
    logic [cPAIR_W-1:0] r_mem [2];
    logic               r_wptr;
    logic               r_rptr;
    logic [1:0]         r_count;
    logic [pCNT_W-1:0]  r_zero_cnt;

    logic               w_clear;
    logic               w_acc;
    logic               w_push;
    logic               w_pop;
    logic [pU0_W-1:0]   w_u0_raw;
    logic               w_zero;
    logic [pU0_W-1:0]   w_u0;
    logic [pU1_W-1:0]   w_u1;
    logic [cPAIR_W-1:0] w_pair;
    logic               w_cnt_max;

    // Ready depends only on registered state so upstream never sees a
    // combinational path from irdy or ival. In S_A a word only goes to the
    // hold register, so it can be taken even with a full buffer.
    assign ordy = (r_state == S_A) | (r_count != 2'd2);
    assign oval = (r_count != 2'd0);

    // Clear overrides any accept or pop happening in the same cycle.
    assign w_clear = iclkena & iclear;
    assign w_acc   = iclkena & ival & ordy & ~iclear;
    assign w_push  = w_acc & (r_state == S_B);
    assign w_pop   = iclkena & oval & irdy & ~iclear;

    // u0 takes word A plus the top of word B; u1 takes the bottom of word B.
    // A zero u0 would blow up -ln, so it is replaced by the smallest nonzero value.
    assign w_u0_raw  = {r_hold, idat[31 -: cLOW_W]};
    assign w_u1      = idat[pU1_W-1:0];
    assign w_zero    = (w_u0_raw == '0);
    assign w_u0      = w_zero ? pU0_W'(1) : w_u0_raw;
    assign w_pair    = {w_u0, w_u1};
    assign w_cnt_max = (r_zero_cnt == {pCNT_W{1'b1}});

    assign ou0       = r_mem[r_rptr][cPAIR_W-1 -: pU0_W];
    assign ou1       = r_mem[r_rptr][pU1_W-1:0];
    assign ozero_cnt = r_zero_cnt;

    // Pair-assembly FSM: word A waits in the hold register until word B arrives.
    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            r_state <= S_A;
            r_hold  <= '0;
        end else if (w_clear) begin
            r_state <= S_A;
            r_hold  <= '0;
        end else if (w_acc) begin
            if (r_state == S_A) begin
                r_hold  <= idat;
                r_state <= S_B;
            end else begin
                r_state <= S_A;
            end
        end
    end

    // Two-entry FWFT buffer; head entry drives the outputs and simply holds
    // its last contents when the buffer drains.
    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else if (w_clear) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= w_pair;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Saturating count of zero-u0 substitutions, bumped only when the pair is pushed.
    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            r_zero_cnt <= '0;
        end else if (w_clear) begin
            r_zero_cnt <= '0;
        end else if (w_push && w_zero && !w_cnt_max) begin
            r_zero_cnt <= r_zero_cnt + pCNT_W'(1);
        end
    end

endmodule

// File: tb/tb_bm_uniform_former.sv
// tb_bm_uniform_former
// Scoreboard bench: expected operand pairs are queued as word B is accepted
// and compared against ou0/ou1 whenever the downstream pops.
module tb_bm_uniform_former;

    logic        iclk = 1'b0;
    logic        ireset_n;
    logic        iclkena;
    logic        iclear;
    logic        ival;
    logic [31:0] idat;
    logic        ordy;
    logic        oval;
    logic [47:0] ou0;
    logic [15:0] ou1;
    logic        irdy;
    logic [7:0]  ozero_cnt;

    int          total = 0;
    int          bad = 0;
    logic [63:0] expQ[$];
    logic [31:0] wordQ[$];
    bit          mState = 1'b0;
    logic [31:0] mHold = '0;
    int          mZcnt = 0;
    int          popCount = 0;
    bit          acc;

    bm_uniform_former #(.pU0_W(48), .pU1_W(16), .pCNT_W(8)) dut (
        .iclk      (iclk),
        .ireset_n  (ireset_n),
        .iclkena   (iclkena),
        .iclear    (iclear),
        .ival      (ival),
        .idat      (idat),
        .ordy      (ordy),
        .oval      (oval),
        .ou0       (ou0),
        .ou1       (ou1),
        .irdy      (irdy),
        .ozero_cnt (ozero_cnt)
    );

    always #5 iclk = ~iclk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at the falling edge, check the model, advance.
    task automatic applyStimulus(input bit clkena, input bit clr, input bit val,
                                 input logic [31:0] dat, input bit rdy, output bit accepted);
        bit          mOrdy;
        bit          doPop;
        logic [63:0] full;
        logic [47:0] u0;
        iclkena = clkena;
        iclear  = clr;
        ival    = val;
        idat    = dat;
        irdy    = rdy;
        #1;
        mOrdy = (mState == 1'b0) || (expQ.size() < 2);
        checkOutput("ordy", 64'(ordy), 64'(mOrdy));
        checkOutput("oval", 64'(oval), 64'(expQ.size() != 0));
        checkOutput("zero_cnt", 64'(ozero_cnt), 64'(mZcnt));
        doPop    = clkena && (expQ.size() != 0) && rdy && !clr;
        accepted = clkena && val && mOrdy && !clr;
        if (doPop) begin
            checkOutput("ou0", 64'(ou0), 64'(expQ[0][63:16]));
            checkOutput("ou1", 64'(ou1), 64'(expQ[0][15:0]));
            void'(expQ.pop_front());
            popCount++;
        end
        if (clkena && clr) begin
            mState = 1'b0;
            mHold  = '0;
            expQ.delete();
            mZcnt  = 0;
        end else if (accepted) begin
            if (mState == 1'b0) begin
                mHold  = dat;
                mState = 1'b1;
            end else begin
                full = {mHold, dat};
                u0   = full[63:16];
                if (u0 == 48'd0) begin
                    u0 = 48'd1;
                    if (mZcnt < 255) mZcnt++;
                end
                expQ.push_back({u0, full[15:0]});
                mState = 1'b0;
            end
        end
        @(negedge iclk);
    endtask

    // Offers every word in wordQ, holding each until it is accepted.
    task automatic sendWords(input bit rdy, input int maxCycles);
        int  idx = 0;
        int  cyc = 0;
        bit  a;
        while (idx < wordQ.size() && cyc < maxCycles) begin
            applyStimulus(1'b1, 1'b0, 1'b1, wordQ[idx], rdy, a);
            if (a) idx++;
            cyc++;
        end
        checkOutput("send_timeout", 64'(idx), 64'(wordQ.size()));
        wordQ.delete();
    endtask

    // Pops until the expected queue is empty.
    task automatic drain(input int maxCycles);
        int cyc = 0;
        bit a;
        while (expQ.size() != 0 && cyc < maxCycles) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, a);
            cyc++;
        end
        checkOutput("drain_timeout", 64'(expQ.size()), 64'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, a);
    endtask

    initial begin
        int startPops;
        ireset_n = 1'b0;
        iclkena  = 1'b0;
        iclear   = 1'b0;
        ival     = 1'b0;
        idat     = '0;
        irdy     = 1'b0;
        repeat (3) @(negedge iclk);
        checkOutput("rst_oval", 64'(oval), 64'd0);
        checkOutput("rst_ou0", 64'(ou0), 64'd0);
        checkOutput("rst_ou1", 64'(ou1), 64'd0);
        checkOutput("rst_zero_cnt", 64'(ozero_cnt), 64'd0);
        checkOutput("rst_ordy", 64'(ordy), 64'd1);
        ireset_n = 1'b1;
        @(negedge iclk);

        $display("[TB] basic pair");
        wordQ.push_back(32'h12345678);
        wordQ.push_back(32'h9ABCDEF0);
        sendWords(1'b1, 10);
        checkOutput("lat_oval", 64'(oval), 64'd1);
        checkOutput("basic_ou0", 64'(ou0), 64'h123456789ABC);
        checkOutput("basic_ou1", 64'(ou1), 64'hDEF0);
        drain(10);

        $display("[TB] zero substitution");
        wordQ.push_back(32'h00000000);
        wordQ.push_back(32'h0000BEEF);
        sendWords(1'b1, 10);
        checkOutput("zs_ou0", 64'(ou0), 64'd1);
        checkOutput("zs_ou1", 64'(ou1), 64'hBEEF);
        checkOutput("zs_cnt1", 64'(ozero_cnt), 64'd1);
        for (int i = 0; i < 299; i++) begin
            wordQ.push_back(32'h00000000);
            wordQ.push_back(32'h0000BEEF);
        end
        sendWords(1'b1, 1000);
        drain(10);
        checkOutput("zs_sat", 64'(ozero_cnt), 64'd255);

        $display("[TB] backpressure");
        for (int i = 1; i <= 5; i++) wordQ.push_back(32'(i));
        sendWords(1'b0, 20);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 32'h6, 1'b0, acc);
            checkOutput("bp_stall", 64'(acc), 64'd0);
        end
        checkOutput("bp_ordy", 64'(ordy), 64'd0);
        wordQ.push_back(32'h6);
        sendWords(1'b1, 10);
        drain(10);

        $display("[TB] streaming");
        startPops = popCount;
        for (int i = 0; i < 100; i++) wordQ.push_back(32'h100 + 32'(i * 7919));
        sendWords(1'b1, 200);
        drain(10);
        checkOutput("stream_pairs", 64'(popCount - startPops), 64'd50);

        $display("[TB] clock enable freeze");
        wordQ.push_back(32'h11112222);
        wordQ.push_back(32'h33334444);
        wordQ.push_back(32'hAAAA0001);
        sendWords(1'b0, 10);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 1'(i), $urandom, 1'(~i), acc);
            checkOutput("frz_ou0", 64'(ou0), 64'h111122223333);
        end
        wordQ.push_back(32'h5555BBBB);
        sendWords(1'b1, 10);
        drain(10);

        $display("[TB] synchronous clear");
        wordQ.push_back(32'h0BAD0001);
        sendWords(1'b1, 10);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0BAD0002, 1'b1, acc);
        checkOutput("clr_oval", 64'(oval), 64'd0);
        checkOutput("clr_ordy", 64'(ordy), 64'd1);
        wordQ.push_back(32'hCAFE0001);
        wordQ.push_back(32'hCAFE0002);
        sendWords(1'b1, 10);
        checkOutput("clr_ou0", 64'(ou0), 64'hCAFE0001CAFE);
        drain(10);

        $display("[TB] async reset mid-pair");
        wordQ.push_back(32'h00000000);
        wordQ.push_back(32'h0000BEEF);
        wordQ.push_back(32'h77770001);
        sendWords(1'b0, 10);
        #2 ireset_n = 1'b0;
        #1;
        checkOutput("arst_oval", 64'(oval), 64'd0);
        checkOutput("arst_ordy", 64'(ordy), 64'd1);
        checkOutput("arst_zero_cnt", 64'(ozero_cnt), 64'd0);
        mState = 1'b0;
        mHold  = '0;
        expQ.delete();
        mZcnt  = 0;
        @(negedge iclk);
        ireset_n = 1'b1;
        wordQ.push_back(32'h24681357);
        wordQ.push_back(32'h8642FEDC);
        sendWords(1'b1, 10);
        checkOutput("arst_ou0", 64'(ou0), 64'h246813578642);
        drain(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bm_uniform_former.md
Name: bm_uniform_former

Overview:
- Downstream neighbour of the Tausworthe URNG in the Box-Muller AWGN chain.
- Consumes 32-bit uniform words two at a time and packs each pair into one Box-Muller operand set: u0 (wide, never zero, feeds the -ln path) and u1 (narrow, feeds the cos/sin path).
- A valid/ready handshake and a 2-entry output buffer decouple the free-running URNG from the stalling log/sqrt/trig pipeline.

Parameters:
- pU0_W, 48, u0 width; legal range 33..63.
- pU1_W, 64-pU0_W, u1 width; pU0_W+pU1_W must equal 64.
- pCNT_W, 8, width of the saturating zero-substitution counter.

Ports:
- iclk  in  1  clock.
- ireset_n  in  1  asynchronous reset, active-low.
- iclkena  in  1  global clock enable; when 0 all state holds.
- iclear  in  1  synchronous restart, qualified by iclkena.
- ival  in  1  upstream word valid.
- idat  in  32  upstream uniform word.
- ordy  out  1  ready to upstream.
- oval  out  1  operand pair valid.
- ou0  out  pU0_W  uniform u0, never 0.
- ou1  out  pU1_W  uniform u1.
- irdy  in  1  downstream ready.
- ozero_cnt  out  pCNT_W  count of u0 zero substitutions, saturating.

Behaviour:
- Reset (ireset_n=0, async):
  - state=S_A, hold register=0, FIFO count=0.
  - oval=0, ou0=0, ou1=0, ozero_cnt=0, ordy=1.
- Handshake qualifiers:
  - acc = iclkena & ival & ordy.
  - pop = iclkena & oval & irdy.
- ordy = (state==S_A) | (count<2).
  - Registered-state only; no combinational path from irdy or ival.
- FSM:
  - S_A: on acc, capture idat as word A into hold, go to S_B.
  - S_B: on acc, take idat as word B, push the formed pair into the FIFO, go to S_A.
  - No acc: state holds.
- Pair forming:
  - u0 = {A, B[31 -: pU0_W-32]}.
  - u1 = B[pU1_W-1:0].
  - If the formed u0==0, substitute u0=1 and increment ozero_cnt. The counter saturates at 2^pCNT_W-1.
- FIFO:
  - 2 entries of pU0_W+pU1_W bits, first-word-fall-through.
  - oval = (count!=0); ou0/ou1 = head entry.
  - Latency: word B accepted in cycle n gives oval=1 in cycle n+1 when the FIFO was empty.
  - Push and pop in the same cycle: count unchanged, data order preserved.
  - Push only possible while count<2 (guaranteed by ordy in S_B).
  - When count=0, ou0/ou1 hold their last value; they are don't-care.
- iclkena=0: no acc, no pop, no state or counter change; ival/irdy ignored; outputs stable.
- iclear=1 with iclkena=1:
  - state→S_A, count→0, hold→0, ozero_cnt→0, oval→0 next cycle.
  - Overrides a simultaneous acc or pop: the word is dropped and nothing is popped.
  - A half-formed pair is discarded.
- Reset mid-pair: the same discard occurs asynchronously.
- Throughput: one pair per 2 accepted words. Sustained when irdy=1 and ival=1 every cycle.

Test Plan:
- Reset, then ival=1 with idat=0x12345678 followed by idat=0x9ABCDEF0, irdy=1:
  - ou0=0x123456789ABC, ou1=0xDEF0.
  - oval pulses 1 cycle after the second accept.
- Zero substitution: words 0x00000000 then 0x0000BEEF:
  - ou0=1, ou1=0xBEEF, ozero_cnt=1.
  - 300 such pairs give ozero_cnt=255 (saturated).
- Backpressure: irdy=0, stream 6 words 0x1..0x6:
  - After 4 words count=2; in S_A ordy stays 1 and word 0x5 is accepted; ordy=0 in S_B, so 0x6 stalls.
  - With irdy=1, pairs pop in order (0x1,0x2), (0x3,0x4), then (0x5,0x6).
  - No loss, no duplication.
- Simultaneous push and pop at count=1, continuous ival/irdy for 100 words:
  - 50 pairs out, in order.
  - count never exceeds 1.
- iclkena=0 for 5 cycles mid-pair while ival and irdy toggle:
  - State, count and outputs are frozen.
  - Resuming completes the pair using the next accepted word.
- iclear after word A only, with acc in the same cycle:
  - Both words are dropped; oval=0, state=S_A.
  - The next two words form the pair.
  - Async ireset_n low mid-pair gives the same result, with ozero_cnt=0.
